// File: rtl/rom_burst_reader_if.sv
// Bus between the burst reader and its environment: start/base request, ROM port, capture results.
// The slave modport is the reader itself; the master side drives start, base_addr and the ROM data.
interface rom_burst_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 32
);
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W-1:0]       rom_address;
  logic                    rom_rden;
  logic [DATA_W-1:0]       rom_q;
  logic                    busy;
  logic                    done;
  logic [DEPTH-1:0]        word_valid;
  logic [DEPTH*DATA_W-1:0] rom_data;

  modport master (
    output start, base_addr, rom_q,
    input  rom_address, rom_rden, busy, done, word_valid, rom_data
  );

  modport slave (
    input  start, base_addr, rom_q,
    output rom_address, rom_rden, busy, done, word_valid, rom_data
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Reads DEPTH consecutive words from a synchronous ROM starting at a latched base address
// and captures them into a parallel register array with per-word valid bits.
module rom_burst_reader #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  rom_burst_reader_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_rden;
  logic                    r_busy;
  logic                    r_done;
  logic [DEPTH-1:0]        r_word_valid;
  logic [DEPTH*DATA_W-1:0] r_rom_data;
  logic [IDX_W-1:0]        r_cnt;
  logic                    r_pipe_vld [ROM_LATENCY];
  logic [IDX_W-1:0]        r_pipe_idx [ROM_LATENCY];

  wire             w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  wire             w_issue    = (r_state == S_ISSUE);
  wire             w_cap      = r_pipe_vld[ROM_LATENCY-1];
  wire [IDX_W-1:0] w_cap_idx  = r_pipe_idx[ROM_LATENCY-1];
  wire             w_last_cap = w_cap && (w_cap_idx == LAST_IDX);

  assign bus.rom_address = r_addr;
  assign bus.rom_rden    = r_rden;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.word_valid  = r_word_valid;
  assign bus.rom_data    = r_rom_data;

  // NOTE: all state, including the whole capture array, is cleared by reset and updated
  // with non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rden       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_valid <= '0;
      r_rom_data   <= '0;
      r_cnt        <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        r_pipe_vld[s] <= 1'b0;
        r_pipe_idx[s] <= '0;
      end
    end else begin
      // Tag pipeline tracks which word index rom_q belongs to on each edge.
      r_pipe_vld[0] <= w_issue;
      r_pipe_idx[0] <= r_cnt;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_idx[s] <= r_pipe_idx[s-1];
      end

      if (w_cap) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_cap_idx == IDX_W'(k)) begin
            r_rom_data[k*DATA_W +: DATA_W] <= bus.rom_q;
            r_word_valid[k]                <= 1'b1;
          end
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_addr       <= bus.base_addr;
            r_rden       <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_word_valid <= '0;
            r_cnt        <= '0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == LAST_IDX) begin
            r_rden  <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          // The final tag leaving the pipeline means nothing is left in flight.
          if (w_last_cap) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomized bench for rom_burst_reader: three instances (latency 1, latency 2, DEPTH=1)
// against a word-level reference of expected addresses, timing and captured data.
module tb_rom_burst_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .DEPTH(32)) b0 ();
  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .DEPTH(32)) b1 ();
  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .DEPTH(1))  b2 ();

  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .DEPTH(32), .ROM_LATENCY(1))
    u_lat1 (.clk(clk), .reset(reset), .bus(b0));
  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .DEPTH(32), .ROM_LATENCY(2))
    u_lat2 (.clk(clk), .reset(reset), .bus(b1));
  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .DEPTH(1), .ROM_LATENCY(1))
    u_dep1 (.clk(clk), .reset(reset), .bus(b2));

  // ROM models: read data is garbage whenever the read enable was low.
  logic [7:0] rom_mem [64];
  logic [7:0] lat2_stage;

  always @(posedge clk) begin
    b0.rom_q   <= b0.rom_rden ? rom_mem[b0.rom_address] : 8'($urandom);
    b2.rom_q   <= b2.rom_rden ? rom_mem[b2.rom_address] : 8'($urandom);
    lat2_stage <= b1.rom_rden ? rom_mem[b1.rom_address] : 8'($urandom);
    b1.rom_q   <= lat2_stage;
  end

  int sel;
  logic         s_rden, s_busy, s_done;
  logic [5:0]   s_addr;
  logic [31:0]  s_valid;
  logic [255:0] s_data;

  always_comb begin
    s_rden = 1'b0; s_busy = 1'b0; s_done = 1'b0;
    s_addr = '0;   s_valid = '0;  s_data = '0;
    case (sel)
      0: begin
        s_rden = b0.rom_rden; s_busy = b0.busy; s_done = b0.done;
        s_addr = b0.rom_address; s_valid = b0.word_valid; s_data = b0.rom_data;
      end
      1: begin
        s_rden = b1.rom_rden; s_busy = b1.busy; s_done = b1.done;
        s_addr = b1.rom_address; s_valid = b1.word_valid; s_data = b1.rom_data;
      end
      default: begin
        s_rden = b2.rom_rden; s_busy = b2.busy; s_done = b2.done;
        s_addr = b2.rom_address; s_valid = 32'(b2.word_valid); s_data = 256'(b2.rom_data);
      end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [5:0] ba);
    case (d)
      0:       begin b0.start = st; b0.base_addr = ba; end
      1:       begin b1.start = st; b1.base_addr = ba; end
      default: begin b2.start = st; b2.base_addr = ba; end
    endcase
  endtask

  task automatic fill_rom(input bit randomize);
    for (int a = 0; a < 64; a++)
      rom_mem[a] = randomize ? 8'($urandom) : (8'(a) ^ 8'hA5);
  endtask

  task automatic check_words(input string nm, input int depth, input logic [5:0] base);
    logic [5:0]  a;
    logic [31:0] mask;
    mask = 32'((64'(1) << depth) - 64'(1));
    check({nm, "_valid"}, s_valid, mask);
    for (int k = 0; k < depth; k++) begin
      a = base + 6'(k);
      check($sformatf("%s_word%0d", nm, k), s_data[k*8 +: 8], rom_mem[a]);
    end
  endtask

  // mode 0: single start pulse; 1: random start pulses and base changes mid-burst;
  // 2: start held high so a second burst follows immediately.
  task automatic run_burst(input int d, input logic [5:0] base, input int mode, input string nm);
    int depth, lat, rden_cnt, done_cyc, waited;
    logic [5:0] a_exp;
    depth = (d == 2) ? 1 : 32;
    lat   = (d == 1) ? 2 : 1;
    sel   = d;
    @(negedge clk);
    drive(d, 1'b1, base);
    @(posedge clk);
    rden_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i <= depth + lat; i++) begin
      @(negedge clk);
      if (s_rden) begin
        a_exp = base + 6'(i);
        check($sformatf("%s_addr%0d", nm, i), s_addr, a_exp);
        rden_cnt++;
      end
      if (i == 0) begin
        check({nm, "_busy_start"}, s_busy, 1'b1);
        check({nm, "_done_start"}, s_done, 1'b0);
        check({nm, "_valid_start"}, s_valid, 32'd0);
      end
      if (s_done && done_cyc < 0) done_cyc = i;
      check($sformatf("%s_excl%0d", nm, i), s_busy & s_done, 1'b0);
      case (mode)
        1:       drive(d, (i < depth + lat) ? 1'($urandom) : 1'b0, 6'($urandom));
        2:       drive(d, 1'b1, base);
        default: drive(d, 1'b0, base);
      endcase
    end
    check({nm, "_rden_cnt"}, rden_cnt, depth);
    check({nm, "_done_cyc"}, done_cyc, depth + lat);
    check({nm, "_busy_end"}, s_busy, 1'b0);
    check_words(nm, depth, base);

    @(negedge clk);
    if (mode == 2) begin
      check({nm, "_re_done"}, s_done, 1'b0);
      check({nm, "_re_busy"}, s_busy, 1'b1);
      check({nm, "_re_valid"}, s_valid, 32'd0);
      check({nm, "_re_rden"}, s_rden, 1'b1);
      check({nm, "_re_addr"}, s_addr, base);
      drive(d, 1'b0, base);
      waited = 0;
      while (!s_done && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check({nm, "_re_timeout"}, s_done, 1'b1);
      check_words({nm, "_re"}, depth, base);
    end else begin
      check({nm, "_hold_done"}, s_done, 1'b1);
      check({nm, "_hold_rden"}, s_rden, 1'b0);
      check({nm, "_hold_busy"}, s_busy, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_rden"},  s_rden,  1'b0);
    check({nm, "_addr"},  s_addr,  6'd0);
    check({nm, "_busy"},  s_busy,  1'b0);
    check({nm, "_done"},  s_done,  1'b0);
    check({nm, "_valid"}, s_valid, 32'd0);
    check({nm, "_data"},  s_data,  256'd0);
  endtask

  initial begin
    logic [5:0] base;
    reset = 1'b1;
    sel   = 0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    fill_rom(1'b0);
    #12;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check_all_zero($sformatf("rst%0d", d));
    end
    @(negedge clk);
    reset = 1'b0;

    run_burst(0, 6'd0, 0, "lat1_base0");
    fill_rom(1'b1);
    run_burst(0, 6'd50, 1, "lat1_wrap");
    base = 6'($urandom);
    run_burst(0, base, 2, "lat1_hold");

    fill_rom(1'b0);
    run_burst(1, 6'd0, 0, "lat2_base0");
    fill_rom(1'b1);
    base = 6'($urandom);
    run_burst(1, base, 1, "lat2_rand");

    run_burst(2, 6'd7, 0, "dep1_b7");
    base = 6'($urandom);
    run_burst(2, base, 1, "dep1_rand");

    // Asynchronous reset in the middle of a burst.
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 6'($urandom));
    @(negedge clk);
    drive(0, 1'b0, '0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("postrst");
    fill_rom(1'b1);
    base = 6'($urandom);
    run_burst(0, base, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
